// File: rtl/gmii_tx_mac.sv
`timescale 1ns / 1ps
// GMII transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS, fixed inter-frame gap.
// A source underrun aborts the frame with one txer cycle and no FCS.
module gmii_tx_mac #(
    parameter int unsigned MIN_FRAME = 60,
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic       gmii_txc,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_txen,
    output logic       gmii_txer,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg
    } state_e;

    localparam logic [31:0] CrcPoly = 32'hEDB88320;
    localparam logic [16:0] MinLen  = 17'(MIN_FRAME);
    localparam logic [15:0] IfgLast = 16'(IFG_BYTES - 1);

    state_e      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic [15:0] ifg_cnt_q, ifg_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        txer_q, txer_d;
    logic        done_pend_q, done_pend_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;

    logic [16:0] cnt_inc;
    logic [15:0] cnt_sat;
    logic [31:0] fcs_word;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;
    assign cnt_sat  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign fcs_word = (~crc_q) >> {fcs_idx_q, 3'b000};

    assign s_ready    = (state_q == StData);
    assign tx_busy    = (state_q != StIdle);
    assign gmii_txd   = txd_q;
    assign gmii_txen  = txen_q;
    assign gmii_txer  = txer_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        cnt_d        = cnt_q;
        fcs_idx_d    = fcs_idx_q;
        ifg_cnt_d    = ifg_cnt_q;
        crc_d        = crc_q;
        txd_d        = 8'h00;
        txen_d       = 1'b0;
        txer_d       = 1'b0;
        done_pend_d  = 1'b0;
        underrun_d   = 1'b0;
        // A good frame's done pulse trails its last FCS byte by one cycle.
        frame_done_d = done_pend_q;

        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    state_d   = StPreamble;
                    pre_cnt_d = 3'd0;
                end
            end
            StPreamble: begin
                txen_d    = 1'b1;
                txd_d     = 8'h55;
                pre_cnt_d = pre_cnt_q + 3'd1;
                if (pre_cnt_q == 3'd6) begin
                    state_d = StSfd;
                end
            end
            StSfd: begin
                txen_d    = 1'b1;
                txd_d     = 8'hD5;
                crc_d     = 32'hFFFF_FFFF;
                cnt_d     = 16'd0;
                fcs_idx_d = 2'd0;
                state_d   = StData;
            end
            StData: begin
                txen_d = 1'b1;
                if (s_valid) begin
                    txd_d = s_data;
                    crc_d = crc_next(crc_q, s_data);
                    cnt_d = cnt_sat;
                    if (s_last) begin
                        state_d = (cnt_inc < MinLen) ? StPad : StFcs;
                    end
                end else begin
                    txer_d       = 1'b1;
                    underrun_d   = 1'b1;
                    frame_done_d = 1'b1;
                    ifg_cnt_d    = 16'd0;
                    state_d      = StIfg;
                end
            end
            StPad: begin
                txen_d = 1'b1;
                crc_d  = crc_next(crc_q, 8'h00);
                cnt_d  = cnt_sat;
                if (cnt_inc >= MinLen) begin
                    state_d = StFcs;
                end
            end
            StFcs: begin
                txen_d    = 1'b1;
                txd_d     = fcs_word[7:0];
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (fcs_idx_q == 2'd3) begin
                    done_pend_d = 1'b1;
                    ifg_cnt_d   = 16'd0;
                    state_d     = StIfg;
                end
            end
            StIfg: begin
                ifg_cnt_d = ifg_cnt_q + 16'd1;
                if (ifg_cnt_q == IfgLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pre_cnt_q    <= 3'd0;
            cnt_q        <= 16'd0;
            fcs_idx_q    <= 2'd0;
            ifg_cnt_q    <= 16'd0;
            crc_q        <= 32'hFFFF_FFFF;
            txd_q        <= 8'h00;
            txen_q       <= 1'b0;
            txer_q       <= 1'b0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            fcs_idx_q    <= fcs_idx_d;
            ifg_cnt_q    <= ifg_cnt_d;
            crc_q        <= crc_d;
            txd_q        <= txd_d;
            txen_q       <= txen_d;
            txer_q       <= txer_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_gmii_tx_mac.sv
`timescale 1ns / 1ps
// Scoreboard bench for gmii_tx_mac: expected GMII byte stream and txen run lengths are queued
// as frames are driven and checked against the selected DUT on the falling clock edge.
module tb_gmii_tx_mac;

    typedef struct {
        int   len;
        logic done;
    } len_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       use0 = 1'b0;
    logic       mon_en = 1'b0;
    logic       gap_chk = 1'b0;

    logic       val_a, rdy_a, txen_a, txer_a, busy_a, done_a, urun_a;
    logic [7:0] txd_a;
    logic       val_z, rdy_z, txen_z, txer_z, busy_z, done_z, urun_z;
    logic [7:0] txd_z;

    logic       m_rdy, m_txen, m_txer, m_busy, m_done, m_urun;
    logic [7:0] m_txd;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    len_t       len_q[$];
    logic [7:0] pl[$];

    always #4 clk = ~clk;

    assign val_a  = s_valid & ~use0;
    assign val_z  = s_valid & use0;
    assign m_rdy  = use0 ? rdy_z  : rdy_a;
    assign m_txen = use0 ? txen_z : txen_a;
    assign m_txer = use0 ? txer_z : txer_a;
    assign m_txd  = use0 ? txd_z  : txd_a;
    assign m_busy = use0 ? busy_z : busy_a;
    assign m_done = use0 ? done_z : done_a;
    assign m_urun = use0 ? urun_z : urun_a;

    gmii_tx_mac u_dut (
        .gmii_txc  (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (val_a),
        .s_last    (s_last),
        .s_ready   (rdy_a),
        .gmii_txd  (txd_a),
        .gmii_txen (txen_a),
        .gmii_txer (txer_a),
        .tx_busy   (busy_a),
        .frame_done(done_a),
        .underrun  (urun_a)
    );

    gmii_tx_mac #(
        .MIN_FRAME(0),
        .IFG_BYTES(12)
    ) u_dut_nopad (
        .gmii_txc  (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (val_z),
        .s_last    (s_last),
        .s_ready   (rdy_z),
        .gmii_txd  (txd_z),
        .gmii_txen (txen_z),
        .gmii_txer (txer_z),
        .tx_busy   (busy_z),
        .frame_done(done_z),
        .underrun  (urun_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Software CRC-32: fold each byte into the low bits, then eight reflected shifts.
    function automatic logic [31:0] crc_model(input logic [7:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int k = 0; k < 8; k++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // Monitor: txen-high cycles pop the byte queue; falling edges pop the length queue.
    logic       prev_en = 1'b0;
    int         run = 0;
    int         gap = 0;
    logic [8:0] e;
    len_t       l;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_en = 1'b0;
            run     = 0;
            gap     = 0;
        end else begin
            if (m_txen) begin
                if (!prev_en && gap_chk) check("b2b_gap", 32'(gap), 32'd13);
                if (exp_q.size() == 0) begin
                    check("unexpected_txen", 32'(m_txen), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("txd", 32'(m_txd), 32'(e[7:0]));
                    check("txer", 32'(m_txer), 32'(e[8]));
                    check("pulse_in_frame", 32'({m_done, m_urun}), 32'({e[8], e[8]}));
                end
                run++;
                gap = 0;
            end else begin
                if (prev_en) begin
                    if (len_q.size() == 0) begin
                        check("unexpected_fall", 32'(prev_en), 32'd0);
                    end else begin
                        l = len_q.pop_front();
                        check("txen_len", 32'(run), 32'(l.len));
                        check("done_at_end", 32'({m_done, m_urun}), 32'({l.done, 1'b0}));
                    end
                end else begin
                    check("idle_pulse", 32'({m_done, m_urun}), 32'd0);
                end
                run = 0;
                gap++;
            end
            prev_en = m_txen;
        end
    end

    task automatic fill_rand(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input logic [7:0] pay[$], input int abort_after, input bit hold);
        logic [7:0]  body[$];
        logic [31:0] fcs;
        len_t        le;
        int          n, minf, acc, guard;
        bit          hs;
        minf = use0 ? 0 : 60;
        n    = (abort_after >= 0) ? abort_after : pay.size();
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pay[i]});
        if (abort_after >= 0) begin
            exp_q.push_back(9'h100);
            le.len  = 8 + n + 1;
            le.done = 1'b0;
        end else begin
            body = pay;
            while (body.size() < minf) begin
                body.push_back(8'h00);
                exp_q.push_back(9'h000);
            end
            fcs = crc_model(body);
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
            le.len  = 8 + body.size() + 4;
            le.done = 1'b1;
        end
        len_q.push_back(le);

        acc     = 0;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = pay[0];
        s_last  = (pay.size() == 1);
        while (acc < n && guard < 4000) begin
            @(negedge clk);
            hs = m_rdy;
            @(posedge clk);
            #1;
            guard++;
            if (hs) begin
                acc++;
                if (acc < pay.size()) begin
                    s_data = pay[acc];
                    s_last = (acc == pay.size() - 1);
                end
            end
        end
        if (guard >= 4000) check("send_timeout", 32'(acc), 32'(n));
        if (!hold || abort_after >= 0) s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || m_busy) && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("drain", 32'(c < budget), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs_a", 32'({txd_a, txen_a, txer_a, done_a, urun_a, rdy_a, busy_a}), 32'd0);
        check("rst_outs_z", 32'({txd_z, txen_z, txer_z, done_z, urun_z, rdy_z, busy_z}), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("idle_txen", 32'({txen_a, busy_a, txen_z, busy_z}), 32'd0);

        // CRC reference frame on the unpadded instance, then a held-valid follow-on frame.
        use0 = 1'b1;
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
        send_frame(pl, -1, 1'b1);
        gap_chk = 1'b1;
        fill_rand(3);
        send_frame(pl, -1, 1'b0);
        wait_done(500);
        gap_chk = 1'b0;
        use0    = 1'b0;

        // Padding: single byte, then the pad boundary either side.
        pl.delete();
        pl.push_back(8'hAB);
        send_frame(pl, -1, 1'b0);
        wait_done(500);
        fill_rand(59);
        send_frame(pl, -1, 1'b0);
        wait_done(500);
        fill_rand(60);
        send_frame(pl, -1, 1'b0);
        wait_done(500);

        // Back-to-back 64-byte frames with s_valid held high.
        fill_rand(64);
        send_frame(pl, -1, 1'b1);
        gap_chk = 1'b1;
        fill_rand(64);
        send_frame(pl, -1, 1'b0);
        wait_done(500);
        gap_chk = 1'b0;

        // Underrun after 10 bytes.
        fill_rand(20);
        send_frame(pl, 10, 1'b0);
        wait_done(500);

        // Reset during PAD, then a clean frame.
        pl.delete();
        pl.push_back(8'h5A);
        send_frame(pl, -1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'({txd_a, txen_a, txer_a, done_a, urun_a, rdy_a, busy_a}), 32'd0);
        exp_q.delete();
        len_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fill_rand(70);
        send_frame(pl, -1, 1'b0);
        wait_done(500);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
